axis_pattern_source: RTL and testbench

- Upstream feeder for the streamer's store interface.
- On a start pulse, emits one AXI-Stream packet of a programmed byte length.
- Payload is a deterministic incrementing pattern derived from a seed, and TKEEP trims the final beat.
- Used for bring-up and DFX-sequencer self-test: it drives the streamer's slave port in place of DMA.

---
 rtl/axis_pattern_if.sv | 21 ++
 rtl/axis_pattern_source.sv | 110 +++++++++++
 tb/tb_axis_pattern_source.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/axis_pattern_if.sv
// AXI-Stream master bundle used by the pattern source. Signal names match the
// stream port names used by the streamer's slave side.
interface axis_pattern_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]   M_AXI_TDATA;
  logic [DATA_WIDTH/8-1:0] M_AXI_TKEEP;
  logic                    M_AXI_TVALID;
  logic                    M_AXI_TREADY;
  logic                    M_AXI_TLAST;

  modport master (
    output M_AXI_TDATA, M_AXI_TKEEP, M_AXI_TVALID, M_AXI_TLAST,
    input  M_AXI_TREADY
  );

  modport slave (
    input  M_AXI_TDATA, M_AXI_TKEEP, M_AXI_TVALID, M_AXI_TLAST,
    output M_AXI_TREADY
  );
endinterface

// File: rtl/axis_pattern_source.sv
// On a start pulse, emits one AXI-Stream packet of seed+index words whose
// final beat is trimmed with TKEEP to the programmed byte length.
module axis_pattern_source #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  cfg_byte_count,
  input  logic [DATA_WIDTH-1:0] cfg_seed,
  axis_pattern_if.master        m_axis,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  beat_count
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam logic [LEN_WIDTH-1:0] BYTES_L = LEN_WIDTH'(BYTES);

  typedef enum logic [0:0] {IDLE, SEND} state_t;

  state_t                state;
  logic [LEN_WIDTH-1:0]  idx;
  logic [LEN_WIDTH-1:0]  beats_r;
  logic [BYTES-1:0]      last_keep_r;
  logic [DATA_WIDTH-1:0] seed_r;

  logic [LEN_WIDTH-1:0]  start_rem;
  logic [LEN_WIDTH-1:0]  start_beats;
  logic [LEN_WIDTH-1:0]  idx_next;
  logic                  next_is_last;

  // Byte enables for a beat carrying rem valid bytes; rem == 0 means a full word.
  function automatic logic [BYTES-1:0] keep_mask(input logic [LEN_WIDTH-1:0] rem);
    logic [BYTES-1:0] m;
    for (int i = 0; i < BYTES; i++) begin
      m[i] = (rem == '0) || (LEN_WIDTH'(i) < rem);
    end
    return m;
  endfunction

  // Quotient plus a carry for the partial word never exceeds the field width,
  // even at the maximum byte count.
  assign start_rem    = cfg_byte_count % BYTES_L;
  assign start_beats  = (cfg_byte_count / BYTES_L) + LEN_WIDTH'(start_rem != '0);
  assign idx_next     = idx + LEN_WIDTH'(1);
  assign next_is_last = (idx_next == beats_r - LEN_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= IDLE;
      idx                 <= '0;
      beats_r             <= '0;
      last_keep_r         <= '0;
      seed_r              <= '0;
      m_axis.M_AXI_TDATA  <= '0;
      m_axis.M_AXI_TKEEP  <= '0;
      m_axis.M_AXI_TVALID <= 1'b0;
      m_axis.M_AXI_TLAST  <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
      beat_count          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            beat_count  <= '0;
            idx         <= '0;
            beats_r     <= start_beats;
            last_keep_r <= keep_mask(start_rem);
            seed_r      <= cfg_seed;
            if (cfg_byte_count == '0) begin
              done <= 1'b1;
            end else begin
              state               <= SEND;
              busy                <= 1'b1;
              m_axis.M_AXI_TVALID <= 1'b1;
              m_axis.M_AXI_TDATA  <= cfg_seed;
              m_axis.M_AXI_TLAST  <= (start_beats == LEN_WIDTH'(1));
              m_axis.M_AXI_TKEEP  <= (start_beats == LEN_WIDTH'(1)) ? keep_mask(start_rem) : '1;
            end
          end
        end
        SEND: begin
          if (m_axis.M_AXI_TREADY) begin
            beat_count <= beat_count + LEN_WIDTH'(1);
            if (m_axis.M_AXI_TLAST) begin
              state               <= IDLE;
              busy                <= 1'b0;
              done                <= 1'b1;
              m_axis.M_AXI_TVALID <= 1'b0;
              m_axis.M_AXI_TLAST  <= 1'b0;
              m_axis.M_AXI_TDATA  <= '0;
              m_axis.M_AXI_TKEEP  <= '0;
            end else begin
              idx                <= idx_next;
              m_axis.M_AXI_TDATA <= seed_r + DATA_WIDTH'(idx_next);
              m_axis.M_AXI_TLAST <= next_is_last;
              m_axis.M_AXI_TKEEP <= next_is_last ? last_keep_r : '1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_pattern_source.sv
// Directed and randomized packets checked against a per-packet list of
// expected beats built from the byte count and seed.
module tb_axis_pattern_source;
  localparam int DW    = 32;
  localparam int LW    = 16;
  localparam int BYTES = DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [LW-1:0] cfg_byte_count;
  logic [DW-1:0] cfg_seed;
  logic          busy;
  logic          done;
  logic [LW-1:0] beat_count;

  axis_pattern_if #(.DATA_WIDTH(DW)) axis ();

  axis_pattern_source #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .cfg_byte_count (cfg_byte_count),
    .cfg_seed       (cfg_seed),
    .m_axis         (axis),
    .busy           (busy),
    .done           (done),
    .beat_count     (beat_count)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int ready_pct   = 100;
  bit noise_en    = 1'b0;
  bit rdy_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit next_ready();
    if (rdy_q.size() > 0) return rdy_q.pop_front();
    return int'($urandom_range(99)) < ready_pct;
  endfunction

  // Starts one packet and follows it to the done cycle; returns at the
  // sample point of the done cycle so a caller may start again immediately.
  task automatic send(input int count, input logic [DW-1:0] seed);
    logic [DW-1:0] exp_data[$];
    logic [3:0]    exp_keep[$];
    int nb, rem, n, cyc;
    nb  = (count + BYTES - 1) / BYTES;
    rem = count % BYTES;
    for (int i = 0; i < nb; i++) begin
      exp_data.push_back(seed + DW'(i));
      exp_keep.push_back((i == nb - 1 && rem != 0) ? 4'((1 << rem) - 1) : 4'hF);
    end
    start          = 1'b1;
    cfg_byte_count = LW'(count);
    cfg_seed       = seed;
    axis.M_AXI_TREADY = 1'($urandom_range(1));
    step();
    start = 1'b0;
    n = 0;
    cyc = 0;
    while (n < nb) begin
      chk("tvalid", axis.M_AXI_TVALID, 1);
      chk("busy", busy, 1);
      chk("done_early", done, 0);
      chk("tdata", axis.M_AXI_TDATA, exp_data[n]);
      chk("tkeep", axis.M_AXI_TKEEP, exp_keep[n]);
      chk("tlast", axis.M_AXI_TLAST, n == nb - 1);
      chk("beat_count_run", beat_count, n);
      axis.M_AXI_TREADY = next_ready();
      if (noise_en && $urandom_range(3) == 0) begin
        start          = 1'b1;
        cfg_byte_count = LW'($urandom);
        cfg_seed       = $urandom;
      end else begin
        start = 1'b0;
      end
      if (axis.M_AXI_TREADY) n++;
      step();
      cyc++;
      if (cyc > 200 + 20 * nb) begin
        chk("timeout", cyc, 0);
        break;
      end
    end
    start = 1'b0;
    chk("done", done, 1);
    chk("tvalid_end", axis.M_AXI_TVALID, 0);
    chk("busy_end", busy, 0);
    chk("beat_count_end", beat_count, nb);
  endtask

  task automatic idle(input int cycles, input int exp_bc);
    for (int i = 0; i < cycles; i++) begin
      start = 1'b0;
      axis.M_AXI_TREADY = 1'($urandom_range(1));
      step();
      chk("idle_tvalid", axis.M_AXI_TVALID, 0);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_beat_count", beat_count, exp_bc);
    end
  endtask

  initial begin
    int cnt, nb;
    bit b2b;
    reset = 1'b1;
    start = 1'b0;
    cfg_byte_count = '0;
    cfg_seed = '0;
    axis.M_AXI_TREADY = 1'b0;
    step();
    step();
    chk("rst_tdata", axis.M_AXI_TDATA, 0);
    chk("rst_tkeep", axis.M_AXI_TKEEP, 0);
    chk("rst_tvalid", axis.M_AXI_TVALID, 0);
    chk("rst_tlast", axis.M_AXI_TLAST, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_beat_count", beat_count, 0);
    reset = 1'b0;
    idle(2, 0);

    // Full words, then a trimmed last word.
    send(16, 32'h100);
    idle(2, 4);
    send(7, 32'h0);
    idle(1, 2);

    // Fixed backpressure pattern.
    rdy_q = '{1, 0, 0, 1, 0, 1, 1};
    send(16, 32'hABC0);
    idle(1, 4);

    // Zero length, then a seed that wraps.
    send(0, 32'h55);
    idle(1, 0);
    send(12, 32'hFFFF_FFFE);
    idle(1, 3);

    // Start pulses while busy must be ignored.
    noise_en = 1'b1;
    send(20, 32'h1234);
    noise_en = 1'b0;
    idle(1, 5);

    // Start in the done cycle.
    send(8, 32'h10);
    send(5, 32'h20);
    idle(1, 2);

    // Reset after two of four beats.
    start = 1'b1;
    cfg_byte_count = LW'(16);
    cfg_seed = 32'h900;
    axis.M_AXI_TREADY = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("pre_rst_tdata", axis.M_AXI_TDATA, 32'h902);
    chk("pre_rst_beat_count", beat_count, 2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_tvalid", axis.M_AXI_TVALID, 0);
    chk("abort_busy", busy, 0);
    chk("abort_beat_count", beat_count, 0);
    chk("abort_done", done, 0);
    idle(1, 0);
    send(16, 32'h900);
    idle(1, 4);

    // Randomized packets.
    for (int p = 0; p < 30; p++) begin
      ready_pct = int'($urandom_range(20, 100));
      noise_en  = 1'($urandom_range(1));
      cnt = int'($urandom_range(0, 40));
      nb  = (cnt + BYTES - 1) / BYTES;
      send(cnt, $urandom);
      b2b = 1'($urandom_range(1));
      if (!b2b) idle(int'($urandom_range(1, 3)), nb);
    end
    noise_en  = 1'b0;
    ready_pct = 100;
    idle(1, nb);

    // Maximum byte count.
    send(65535, 32'hDEAD_0000);
    idle(1, 16384);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
